// File: rtl/noc_pkg.sv
// Purpose: shared field positions and defaults for the NoC PIO adapters.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: PIO word layout constants, default TDMA frame length, link-word helper.
package noc_pkg;

    localparam int NOC_WORD_W    = 32;
    localparam int TOGGLE_BIT    = 31;
    localparam int DEST_HI       = 30;
    localparam int DEST_LO       = 27;
    localparam int PAYLOAD_W     = 27;
    localparam int NUM_SLOTS_DEF = 16;

    // Link words always carry a set MSB so the receiver can tell a real
    // word from the idle all-zero value; bits [30:0] pass through untouched.
    function automatic logic [NOC_WORD_W-1:0] link_word(input logic [NOC_WORD_W-1:0] entry);
        return {1'b1, entry[NOC_WORD_W-2:0]};
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Purpose: generic synchronous FIFO, DEPTH entries of WIDTH bits (power-of-2 DEPTH >= 2).
// Latency: written word visible at pop_dat the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), push/push_dat, pop, pop_dat (head, combinational),
//        full/empty (registered, occupancy after the edge).
module noc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && !empty_q;
        // A same-cycle pop frees the head slot first, so a full FIFO can still accept.
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign pop_dat = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/noc_tx_adapter.sv
// Purpose: turns bit-31 toggles of the Nios PIO word into queued TDMA NoC link words.
// Latency: 2 cycles minimum from toggle presentation to noc_out_valid, plus up to NUM_SLOTS-1 slot wait.
// Backpressure: none from the NoC; a toggle arriving with the FIFO full and no pop is dropped and flagged.
// Ports: clk, reset (sync, active-high), pio_data[31:0] in; noc_out_data/noc_out_valid link out;
//        tx_full/tx_empty/tx_overflow status; slot_cnt debug; tx_ovf_count[7:0] when
//        NOC_TX_OVF_CNT_EN is defined (saturating drop counter, tx_overflow = count != 0).
module noc_tx_adapter
    import noc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int DEST_W    = 4,
    localparam int SLOT_W   = $clog2(NUM_SLOTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NOC_WORD_W-1:0] pio_data,
    output logic [NOC_WORD_W-1:0] noc_out_data,
    output logic                  noc_out_valid,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic                  tx_overflow,
    output logic [SLOT_W-1:0]     slot_cnt
`ifdef NOC_TX_OVF_CNT_EN
    ,
    output logic [7:0]            tx_ovf_count
`endif
);

    logic [NOC_WORD_W-1:0] head_dat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [SLOT_W-1:0]     head_slot;
    logic                  toggle;
    logic                  pop;
    logic                  drop;

    logic                  last_toggle_q, last_toggle_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic                  out_vld_q, out_vld_d;
    logic [NOC_WORD_W-1:0] out_dat_q, out_dat_d;

    noc_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (NOC_WORD_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (toggle),
        .push_dat (pio_data),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        // Only the low SLOT_W destination bits select a slot: destinations alias modulo NUM_SLOTS.
        head_slot     = head_dat[DEST_LO +: SLOT_W];
        toggle        = (pio_data[TOGGLE_BIT] != last_toggle_q);
        pop           = !fifo_empty && (head_slot == slot_q);
        drop          = toggle && fifo_full && !pop;
        last_toggle_d = pio_data[TOGGLE_BIT];
        // Power-of-2 frame length makes the natural wrap the TDMA wrap.
        slot_d        = slot_q + SLOT_W'(1);
        out_vld_d     = pop;
        out_dat_d     = pop ? link_word(head_dat) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_toggle_q <= 1'b0;
            slot_q        <= '0;
            out_vld_q     <= 1'b0;
            out_dat_q     <= '0;
        end else begin
            last_toggle_q <= last_toggle_d;
            slot_q        <= slot_d;
            out_vld_q     <= out_vld_d;
            out_dat_q     <= out_dat_d;
        end
    end

`ifdef NOC_TX_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign tx_ovf_count = ovf_cnt_q;
    assign tx_overflow  = (ovf_cnt_q != 8'd0);
`else
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign tx_overflow = ovf_q;
`endif

    assign noc_out_data  = out_dat_q;
    assign noc_out_valid = out_vld_q;
    assign tx_full       = fifo_full;
    assign tx_empty      = fifo_empty;
    assign slot_cnt      = slot_q;

endmodule

// File: doc/noc_tx_adapter.md
Name: noc_tx_adapter

Overview:
- Sits directly downstream of the Avalon output PIO that Nios drives to the NoC.
- Consumes the 32-bit PIO output word and detects a new message by a toggle of bit 31.
- Buffers each new message in a small FIFO and injects it onto the TDMA NoC link only in the time slot matching its destination.
- Drives FIFO/overflow status back so software can read it through an input PIO.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- NUM_SLOTS, 16, TDMA frame length in cycles; power of 2, at most 16.
- DEST_W, 4, width of the destination field, bits [30:27].

Ports:
- clk  in  1  system clock, shared with the PIO.
- reset  in  1  synchronous, active-high.
- pio_data  in  32  PIO out_port word:
  - [31] = send toggle
  - [30:27] = destination port
  - [26:0] = payload
- noc_out_data  out  32  NoC link word: {1'b1, entry[30:0]} when valid, else 32'h0.
- noc_out_valid  out  1  one-cycle strobe marking a link word.
- tx_full  out  1  FIFO holds DEPTH entries.
- tx_empty  out  1  FIFO holds 0 entries.
- tx_overflow  out  1  sticky; set when a toggle is seen while the FIFO is full and no pop occurs.
- slot_cnt  out  log2(NUM_SLOTS)  current TDMA slot, for debug and the bench.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All state is registered on the rising edge of clk.
- Values in reset:
  - noc_out_data = 0, noc_out_valid = 0
  - tx_full = 0, tx_empty = 1, tx_overflow = 0
  - slot_cnt = 0, last_toggle = 0 (matches the PIO reset value of 0)
  - FIFO read/write pointers = 0; FIFO contents are don't-care.
- Reset mid-operation: the FIFO is flushed, and any word being emitted is dropped on the next edge.
- Slot counter:
  - slot_cnt increments every cycle and wraps from NUM_SLOTS-1 to 0.
  - It is free-running and never gated.
- Detect and push:
  - A toggle exists when pio_data[31] != last_toggle.
  - On a toggle, last_toggle takes pio_data[31] at that edge, always, even if the word is dropped.
  - The word is written to the FIFO at the same edge.
  - A write is accepted if not full, or if a pop occurs in the same cycle. The pop frees the entry first; occupancy stays DEPTH.
  - Otherwise the word is dropped and tx_overflow is set.
- Pop:
  - Occurs in a cycle when the FIFO is not empty and slot_cnt == head[30:27] (modulo NUM_SLOTS).
  - At that edge: noc_out_valid = 1 and noc_out_data = {1'b1, head[30:0]}; the read pointer advances.
  - Otherwise the next cycle has noc_out_valid = 0 and noc_out_data = 0.
- Latency:
  - Cycle T: the toggle is presented.
  - Edge of T: push.
  - Earliest pop decision: cycle T+1.
  - noc_out_valid high: cycle T+2 at the earliest.
  - Worst case waits up to NUM_SLOTS-1 extra cycles for the head's slot.
- Ordering and blocking:
  - Strict FIFO order; a head waiting for its slot blocks later entries.
  - The NoC has no backpressure; TDMA guarantees acceptance.
- Simultaneous push and pop when empty: impossible, because the push lands after the edge; the pop needs a non-empty FIFO.
- Pointers: wrap modulo DEPTH; occupancy count is clog2(DEPTH)+1 bits.
- Status flags: tx_full and tx_empty are registered and reflect occupancy after the edge.
- Overflow flag: tx_overflow clears only on reset.

Optional Feature:
- Macro: NOC_TX_OVF_CNT_EN.
- Defined:
  - Adds output tx_ovf_count[7:0], which increments on each dropped word and saturates at 255.
  - Cleared only by reset.
  - tx_overflow = (tx_ovf_count != 0).
- Undefined: no counter port; tx_overflow is a plain sticky flop.

Decomposition:
- Shared package noc_pkg holds:
  - constants for field positions: TOGGLE_BIT=31, DEST_HI=30, DEST_LO=27, PAYLOAD_W=27
  - NOC_WORD_W=32
  - the default NUM_SLOTS
- Sub-module noc_sync_fifo is natural: DEPTH/width-parameterised synchronous FIFO with push, pop, full, empty. It is reusable for the matching receive adapter.
- The top level holds toggle detect, slot counter, pop gating and overflow logic.

Test Plan:
- Reset, then hold pio_data=0 for 32 cycles -> noc_out_valid never asserts; tx_empty=1; slot_cnt cycles 0..15 then wraps.
- At slot_cnt=2, write pio_data=32'h9000_0ABC (toggle=1, dest=2) -> push; pop waits for slot 2 of the next frame; noc_out_data=32'h9000_0ABC for exactly one cycle.
- Write dest=5 with the word presented at slot_cnt=4 -> noc_out_valid high 2 cycles after presentation (minimum latency).
- Push dest=7 then dest=1 -> output order preserved; the dest=1 word waits until slot 1 after the dest=7 word emits.
- Five toggles with dest=15, issued faster than slot 15 recurs (DEPTH=4) -> tx_full=1; 5th word dropped; tx_overflow=1 and stays 1; exactly 4 words emitted.
- Assert reset with 3 entries queued -> tx_empty=1 and noc_out_valid=0 after the edge; no queued word ever appears.
- With NOC_TX_OVF_CNT_EN defined, force 300 drops -> tx_ovf_count saturates at 8'hFF.
